// File: rtl/alu_issue_controller_pkg.sv
// alu_issue_controller_pkg
//   Shared constants for the ALU issue controller. It holds the command codes
//   received on req_cmd, the 4-bit ALU control words driven on aluOp, and the
//   controller state encodings.
//   Optional feature macro used by the top: ALU_MUL_EARLY_EXIT_EN.
package alu_issue_controller_pkg;

    // Command codes (req_cmd)
    localparam logic [2:0] CMD_AND = 3'd0;
    localparam logic [2:0] CMD_OR  = 3'd1;
    localparam logic [2:0] CMD_ADD = 3'd2;
    localparam logic [2:0] CMD_SUB = 3'd3;
    localparam logic [2:0] CMD_SLT = 3'd4;
    localparam logic [2:0] CMD_NEG = 3'd5;
    localparam logic [2:0] CMD_MAX = 3'd6;
    localparam logic [2:0] CMD_MUL = 3'd7;

    // ALU control words: [3] negate left, [2] negate right, [1:0] function
    localparam logic [3:0] ALUOP_AND = 4'b0000;
    localparam logic [3:0] ALUOP_OR  = 4'b0001;
    localparam logic [3:0] ALUOP_ADD = 4'b0010;
    localparam logic [3:0] ALUOP_SUB = 4'b0110;
    localparam logic [3:0] ALUOP_SLT = 4'b0111;
    localparam logic [3:0] ALUOP_NEG = 4'b1010;

    // Controller states
    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_EXEC = 3'd1;
    localparam logic [2:0] ST_MAX2 = 3'd2;
    localparam logic [2:0] ST_MUL  = 3'd3;
    localparam logic [2:0] ST_RESP = 3'd4;

endpackage

// File: rtl/alu_issue_controller_cmd_decoder.sv
// alu_cmd_decoder
//   Combinational decode of a 3-bit command into the ALU control word.
//   Ports:
//     cmd            in   3  command code
//     aluop          out  4  ALU control word for the command's (first) ALU step
//     use_zero_right out  1  right operand must be forced to zero (NEG)
//   MAX decodes to SLT (its comparison step); MUL decodes to ADD (its
//   accumulate step).
module alu_cmd_decoder
    import alu_issue_controller_pkg::*;
(
    input  logic [2:0] cmd,
    output logic [3:0] aluop,
    output logic       use_zero_right
);

    always_comb begin
        aluop          = ALUOP_AND;
        use_zero_right = 1'b0;
        case (cmd)
            CMD_AND: aluop = ALUOP_AND;
            CMD_OR:  aluop = ALUOP_OR;
            CMD_ADD: aluop = ALUOP_ADD;
            CMD_SUB: aluop = ALUOP_SUB;
            CMD_SLT: aluop = ALUOP_SLT;
            CMD_NEG: begin
                aluop          = ALUOP_NEG;
                use_zero_right = 1'b1;
            end
            CMD_MAX: aluop = ALUOP_SLT;
            CMD_MUL: aluop = ALUOP_ADD;
            default: aluop = ALUOP_AND;
        endcase
    end

endmodule

// File: rtl/alu_issue_controller.sv
// alu_issue_controller
//   Initiator for a shared 32-bit combinational ALU. Accepts commands over a
//   valid/ready request channel, sequences them through the external ALU
//   (single step, two-step MAX, shift-add MUL) and returns a registered result
//   over a valid/ready response channel.
//   Ports:
//     clk, rst_n                  clock, asynchronous active-low reset
//     req_valid/req_ready         request handshake
//     req_cmd, req_a, req_b       command and operands (captured on accept)
//     rsp_valid/rsp_ready         response handshake
//     rsp_data                    registered result, stable while rsp_valid
//     aluOp, leftOperand,
//     rightOperand                ALU inputs, zero outside EXEC and MUL
//     aluResult                   ALU combinational result
//   Macro ALU_MUL_EARLY_EXIT_EN: when defined, MUL finishes as soon as no set
//   multiplier bits remain instead of always running WIDTH iterations.
module alu_issue_controller
    import alu_issue_controller_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       req_cmd,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic [3:0]       aluOp,
    output logic [WIDTH-1:0] leftOperand,
    output logic [WIDTH-1:0] rightOperand,
    input  logic [WIDTH-1:0] aluResult
);

    logic [2:0]       state_q, state_d;
    logic [2:0]       cmd_q, cmd_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             flag_q, flag_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] rsp_data_q, rsp_data_d;

    logic [3:0]       dec_aluop;
    logic             dec_zero_right;
    logic [WIDTH-1:0] mul_step;
    logic             mul_done;

    alu_cmd_decoder u_dec (
        .cmd            (cmd_q),
        .aluop          (dec_aluop),
        .use_zero_right (dec_zero_right)
    );

    assign req_ready = (state_q == ST_IDLE);
    assign rsp_valid = (state_q == ST_RESP);
    assign rsp_data  = rsp_data_q;

    // ALU inputs are purely a function of state so they are zero whenever the
    // controller is not actively using the ALU.
    always_comb begin
        aluOp        = ALUOP_AND;
        leftOperand  = '0;
        rightOperand = '0;
        case (state_q)
            ST_EXEC: begin
                aluOp        = dec_aluop;
                leftOperand  = a_q;
                rightOperand = dec_zero_right ? '0 : b_q;
            end
            ST_MUL: begin
                aluOp        = ALUOP_ADD;
                leftOperand  = acc_q;
                rightOperand = mcand_q;
            end
            default: ;
        endcase
    end

    // Accumulator value after this iteration; also the final product on the
    // last iteration, so it is captured straight into rsp_data.
    assign mul_step = mplier_q[0] ? aluResult : acc_q;

`ifdef ALU_MUL_EARLY_EXIT_EN
    // Done once the current bit is the last set bit of the multiplier.
    assign mul_done = (mplier_q[WIDTH-1:1] == '0) || (cnt_q == CNT_W'(WIDTH - 1));
`else
    assign mul_done = (cnt_q == CNT_W'(WIDTH - 1));
`endif

    always_comb begin
        state_d    = state_q;
        cmd_d      = cmd_q;
        a_d        = a_q;
        b_d        = b_q;
        flag_d     = flag_q;
        acc_d      = acc_q;
        mcand_d    = mcand_q;
        mplier_d   = mplier_q;
        cnt_d      = cnt_q;
        rsp_data_d = rsp_data_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    cmd_d = req_cmd;
                    a_d   = req_a;
                    b_d   = req_b;
                    if (req_cmd == CMD_MUL) begin
                        acc_d    = '0;
                        mcand_d  = req_a;
                        mplier_d = req_b;
                        cnt_d    = '0;
                        state_d  = ST_MUL;
                    end else begin
                        state_d = ST_EXEC;
                    end
                end
            end
            ST_EXEC: begin
                if (cmd_q == CMD_MAX) begin
                    flag_d  = aluResult[0];
                    state_d = ST_MAX2;
                end else begin
                    rsp_data_d = aluResult;
                    state_d    = ST_RESP;
                end
            end
            ST_MAX2: begin
                // flag set means a < b (wrapped sign of a-b)
                rsp_data_d = flag_q ? b_q : a_q;
                state_d    = ST_RESP;
            end
            ST_MUL: begin
                acc_d    = mul_step;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CNT_W'(1);
                if (mul_done) begin
                    rsp_data_d = mul_step;
                    state_d    = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cmd_q      <= '0;
            a_q        <= '0;
            b_q        <= '0;
            flag_q     <= 1'b0;
            acc_q      <= '0;
            mcand_q    <= '0;
            mplier_q   <= '0;
            cnt_q      <= '0;
            rsp_data_q <= '0;
        end else begin
            state_q    <= state_d;
            cmd_q      <= cmd_d;
            a_q        <= a_d;
            b_q        <= b_d;
            flag_q     <= flag_d;
            acc_q      <= acc_d;
            mcand_q    <= mcand_d;
            mplier_q   <= mplier_d;
            cnt_q      <= cnt_d;
            rsp_data_q <= rsp_data_d;
        end
    end

endmodule

// File: tb/tb_alu_issue_controller.sv
module tb_alu_issue_controller;

    localparam int WIDTH = 32;
    localparam int CNT_W = 6;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             req_valid = 1'b0;
    logic             req_ready;
    logic [2:0]       req_cmd = '0;
    logic [WIDTH-1:0] req_a = '0;
    logic [WIDTH-1:0] req_b = '0;
    logic             rsp_valid;
    logic             rsp_ready = 1'b0;
    logic [WIDTH-1:0] rsp_data;
    logic [3:0]       aluOp;
    logic [WIDTH-1:0] leftOperand;
    logic [WIDTH-1:0] rightOperand;
    logic [WIDTH-1:0] aluResult;

    int vectors = 0;
    int miscompares = 0;

    alu_issue_controller #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_cmd      (req_cmd),
        .req_a        (req_a),
        .req_b        (req_b),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_data     (rsp_data),
        .aluOp        (aluOp),
        .leftOperand  (leftOperand),
        .rightOperand (rightOperand),
        .aluResult    (aluResult)
    );

    always #5 clk = ~clk;

    // External ALU: optional two's-complement negation of each operand, then
    // AND / OR / ADD / SLT (sign of the sum in bit 0).
    logic [WIDTH-1:0] alu_l, alu_r, alu_sum;
    always_comb begin
        alu_l   = aluOp[3] ? (WIDTH'(0) - leftOperand) : leftOperand;
        alu_r   = aluOp[2] ? (WIDTH'(0) - rightOperand) : rightOperand;
        alu_sum = alu_l + alu_r;
        case (aluOp[1:0])
            2'd0:    aluResult = alu_l & alu_r;
            2'd1:    aluResult = alu_l | alu_r;
            2'd2:    aluResult = alu_sum;
            default: aluResult = {{(WIDTH-1){1'b0}}, alu_sum[WIDTH-1]};
        endcase
    end

    function automatic logic [WIDTH-1:0] ref_result(input logic [2:0] cmd,
                                                    input logic [WIDTH-1:0] a,
                                                    input logic [WIDTH-1:0] b);
        logic [WIDTH-1:0] diff;
        logic [WIDTH-1:0] prod;
        diff = a - b;
        prod = a * b;
        case (cmd)
            3'd0:    return a & b;
            3'd1:    return a | b;
            3'd2:    return a + b;
            3'd3:    return diff;
            3'd4:    return {{(WIDTH-1){1'b0}}, diff[WIDTH-1]};
            3'd5:    return WIDTH'(0) - a;
            3'd6:    return diff[WIDTH-1] ? b : a;
            default: return prod;
        endcase
    endfunction

    function automatic int ref_latency(input logic [2:0] cmd, input logic [WIDTH-1:0] b);
        int hi;
        if (cmd <= 3'd5) return 1;
        if (cmd == 3'd6) return 2;
`ifdef ALU_MUL_EARLY_EXIT_EN
        hi = 0;
        for (int i = 0; i < WIDTH; i++) if (b[i]) hi = i;
        return 1 + hi;
`else
        hi = WIDTH;
        return hi;
`endif
    endfunction

    function automatic logic [3:0] ref_op(input logic [2:0] cmd);
        case (cmd)
            3'd0:    return 4'b0000;
            3'd1:    return 4'b0001;
            3'd2:    return 4'b0010;
            3'd3:    return 4'b0110;
            3'd4:    return 4'b0111;
            3'd5:    return 4'b1010;
            3'd6:    return 4'b0111;
            default: return 4'b0010;
        endcase
    endfunction

    task automatic check(input string tag, input logic [WIDTH-1:0] obs,
                         input logic [WIDTH-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one command, check first ALU step, latency, result, backpressure
    // for `hold` cycles, then complete the response handshake.
    task automatic run_cmd(input logic [2:0] cmd, input logic [WIDTH-1:0] a,
                           input logic [WIDTH-1:0] b, input int hold);
        logic [WIDTH-1:0] exp;
        int lat;
        exp = ref_result(cmd, a, b);
        @(negedge clk);
        check("req_ready_idle", WIDTH'(req_ready), 1);
        req_valid = 1'b1;
        req_cmd   = cmd;
        req_a     = a;
        req_b     = b;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_a     = $urandom;
        req_b     = $urandom;
        check("step1_aluop", WIDTH'(aluOp), WIDTH'(ref_op(cmd)));
        check("step1_left", leftOperand, (cmd == 3'd7) ? '0 : a);
        check("step1_right", rightOperand, (cmd == 3'd5) ? '0 : ((cmd == 3'd7) ? a : b));
        lat = 0;
        while (!rsp_valid && lat < WIDTH + 8) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("latency", WIDTH'(lat), WIDTH'(ref_latency(cmd, b)));
        check("rsp_data", rsp_data, exp);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            check("hold_valid", WIDTH'(rsp_valid), 1);
            check("hold_data", rsp_data, exp);
            check("hold_req_ready", WIDTH'(req_ready), 0);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        check("post_rsp_valid", WIDTH'(rsp_valid), 0);
        check("post_req_ready", WIDTH'(req_ready), 1);
        check("post_aluop", WIDTH'(aluOp), 0);
    endtask

    initial begin
        // Reset state
        #2;
        check("rst_req_ready", WIDTH'(req_ready), 1);
        check("rst_rsp_valid", WIDTH'(rsp_valid), 0);
        check("rst_rsp_data", rsp_data, 0);
        check("rst_aluop", WIDTH'(aluOp), 0);
        check("rst_left", leftOperand, 0);
        check("rst_right", rightOperand, 0);
        @(negedge clk);
        rst_n = 1'b1;
        // rsp_ready while idle must not matter
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        check("idle_rsp_valid", WIDTH'(rsp_valid), 0);

        // Directed cases
        run_cmd(3'd2, 32'h7FFF_FFFF, 32'h1, 0);
        run_cmd(3'd3, 32'd5, 32'd7, 1);
        run_cmd(3'd4, 32'd3, 32'd9, 0);
        run_cmd(3'd4, 32'd9, 32'd3, 0);
        run_cmd(3'd4, 32'h8000_0000, 32'd1, 0);
        run_cmd(3'd6, 32'hFFFF_FFFF, 32'd2, 0);
        run_cmd(3'd6, 32'd7, 32'd7, 0);
        run_cmd(3'd5, 32'd1234, 32'hDEAD_BEEF, 0);
        run_cmd(3'd7, 32'd12345, 32'd6789, 0);
        run_cmd(3'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        run_cmd(3'd7, 32'd123, 32'd1, 0);
        run_cmd(3'd7, 32'd55, 32'd0, 0);
        run_cmd(3'd1, 32'hF0F0_0000, 32'h0000_0F0F, 5);

        // Reset in the middle of a MUL
        @(negedge clk);
        req_valid = 1'b1;
        req_cmd   = 3'd7;
        req_a     = 32'h1234_5678;
        req_b     = 32'hFFFF_FFFF;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        check("mid_mul_busy", WIDTH'(req_ready), 0);
        rst_n = 1'b0;
        #1;
        check("abort_rsp_valid", WIDTH'(rsp_valid), 0);
        check("abort_req_ready", WIDTH'(req_ready), 1);
        check("abort_aluop", WIDTH'(aluOp), 0);
        check("abort_left", leftOperand, 0);
        check("abort_right", rightOperand, 0);
        check("abort_rsp_data", rsp_data, 0);
        @(negedge clk);
        rst_n = 1'b1;
        run_cmd(3'd0, 32'hF0, 32'h3C, 0);

        // Randomized commands against the reference model
        for (int n = 0; n < 40; n++) begin
            logic [2:0]       c;
            logic [WIDTH-1:0] ra, rb;
            c  = 3'($urandom_range(0, 7));
            ra = $urandom;
            rb = ($urandom_range(0, 3) == 0) ? WIDTH'($urandom_range(0, 255)) : $urandom;
            run_cmd(c, ra, rb, $urandom_range(0, 3));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
